// File: rtl/fetch_redirect_sequencer_if.sv
// Fetch sequencer bus: stall and redirect requests in; fetch address, squash and statistics out.
// The master drives requests; the slave is the sequencer.
interface fetch_redirect_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             STALL;
    logic             ID_REDIRECT;
    logic [31:0]      ID_TARGET;
    logic             EX_MISPREDICT;
    logic [31:0]      EX_TARGET;
    logic [31:0]      FETCH_PC;
    logic             FETCH_VALID;
    logic             SQUASH_IF;
    logic             PENDING;
    logic [CNT_W-1:0] EX_REDIR_COUNT;
    logic [CNT_W-1:0] ID_REDIR_COUNT;

    modport master (
        output STALL, ID_REDIRECT, ID_TARGET, EX_MISPREDICT, EX_TARGET,
        input  FETCH_PC, FETCH_VALID, SQUASH_IF, PENDING, EX_REDIR_COUNT, ID_REDIR_COUNT
    );

    modport slave (
        input  STALL, ID_REDIRECT, ID_TARGET, EX_MISPREDICT, EX_TARGET,
        output FETCH_PC, FETCH_VALID, SQUASH_IF, PENDING, EX_REDIR_COUNT, ID_REDIR_COUNT
    );
endinterface

// File: rtl/fetch_redirect_sequencer.sv
// Purpose: fetch PC owner choosing EX mispredict, ID redirect or PC+4; REDIRECT_STATS_EN adds redirect counters.
// Latency: a redirect shows on FETCH_PC one cycle after the request; SQUASH_IF is registered with the EX load.
// Backpressure: STALL holds the PC and buffers one redirect (EX beats ID), applied on release.
module fetch_redirect_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int          CNT_W        = 16
) (
    input logic CLK,
    input logic RESET,
    fetch_redirect_sequencer_if.slave bus
);
    typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

    state_t      state, stateNext;
    logic [31:0] fetchPc, pcNext;
    logic        fetchValid;
    logic        squashIf, squashNext;
    logic [31:0] pendTarget, pendTargetNext;
    logic        pendIsEx, pendIsExNext;
    logic        exLoad, idLoad;
    logic [31:0] exTgt, idTgt;

    // Instruction addresses are word aligned; low bits of any target are dropped.
    assign exTgt = bus.EX_TARGET & ~32'd3;
    assign idTgt = bus.ID_TARGET & ~32'd3;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= RUN;
            fetchPc    <= RESET_VECTOR;
            fetchValid <= 1'b0;
            squashIf   <= 1'b0;
            pendTarget <= '0;
            pendIsEx   <= 1'b0;
        end else begin
            state      <= stateNext;
            fetchPc    <= pcNext;
            fetchValid <= 1'b1;
            squashIf   <= squashNext;
            pendTarget <= pendTargetNext;
            pendIsEx   <= pendIsExNext;
        end
    end

    always_comb begin
        stateNext      = state;
        pcNext         = fetchPc;
        pendTargetNext = pendTarget;
        pendIsExNext   = pendIsEx;
        exLoad         = 1'b0;
        idLoad         = 1'b0;
        squashNext     = 1'b0;
        // The first valid cycle after reset holds the reset vector and ignores redirects.
        if (!fetchValid) begin
            stateNext = RUN;
        end else begin
            case (state)
                RUN, HOLD: begin
                    if (bus.STALL) begin
                        if (bus.EX_MISPREDICT) begin
                            pendTargetNext = exTgt;
                            pendIsExNext   = 1'b1;
                            stateNext      = HOLD_PEND;
                        end else if (bus.ID_REDIRECT) begin
                            pendTargetNext = idTgt;
                            pendIsExNext   = 1'b0;
                            stateNext      = HOLD_PEND;
                        end else begin
                            stateNext = HOLD;
                        end
                    end else begin
                        stateNext = RUN;
                        if (bus.EX_MISPREDICT) begin
                            pcNext = exTgt;
                            exLoad = 1'b1;
                        end else if (bus.ID_REDIRECT) begin
                            pcNext = idTgt;
                            idLoad = 1'b1;
                        end else begin
                            pcNext = fetchPc + 32'd4;
                        end
                    end
                end
                HOLD_PEND: begin
                    if (bus.STALL) begin
                        // A pending EX correction must never be displaced by an ID redirect.
                        if (bus.EX_MISPREDICT) begin
                            pendTargetNext = exTgt;
                            pendIsExNext   = 1'b1;
                        end else if (bus.ID_REDIRECT && !pendIsEx) begin
                            pendTargetNext = idTgt;
                        end
                    end else begin
                        if (bus.EX_MISPREDICT) begin
                            pcNext = exTgt;
                            exLoad = 1'b1;
                        end else if (pendIsEx) begin
                            pcNext = pendTarget;
                            exLoad = 1'b1;
                        end else if (bus.ID_REDIRECT) begin
                            pcNext = idTgt;
                            idLoad = 1'b1;
                        end else begin
                            pcNext = pendTarget;
                            idLoad = 1'b1;
                        end
                        pendTargetNext = '0;
                        pendIsExNext   = 1'b0;
                        stateNext      = RUN;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
        squashNext = exLoad;
    end

    assign bus.FETCH_PC    = fetchPc;
    assign bus.FETCH_VALID = fetchValid;
    assign bus.SQUASH_IF   = squashIf;
    assign bus.PENDING     = (state == HOLD_PEND);

`ifdef REDIRECT_STATS_EN
    logic [CNT_W-1:0] exCount, idCount;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            exCount <= '0;
            idCount <= '0;
        end else begin
            if (exLoad && (exCount != '1)) exCount <= exCount + 1'b1;
            if (idLoad && (idCount != '1)) idCount <= idCount + 1'b1;
        end
    end

    assign bus.EX_REDIR_COUNT = exCount;
    assign bus.ID_REDIR_COUNT = idCount;
`else
    assign bus.EX_REDIR_COUNT = {CNT_W{1'b0}};
    assign bus.ID_REDIR_COUNT = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_fetch_redirect_sequencer.sv
// Directed bench for fetch_redirect_sequencer: hand-derived expectations queued per step, checked after each edge.
module tb_fetch_redirect_sequencer;
    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam int SRC_SEQ = 0, SRC_ID = 1, SRC_EX = 2;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        sq;
        logic        pend;
        logic [15:0] exc;
        logic [15:0] idc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [15:0] expEx = '0;
    logic [15:0] expId = '0;

    fetch_redirect_sequencer_if #(.CNT_W(16)) bus();

    fetch_redirect_sequencer #(.RESET_VECTOR(RV), .CNT_W(16)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compareOut(input int n);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL step%0d scoreboard_empty observed=0 expected=1", n);
        end else begin
            e = sb.pop_front();
            check($sformatf("step%0d_pc", n), bus.FETCH_PC, e.pc);
            check($sformatf("step%0d_valid", n), {31'd0, bus.FETCH_VALID}, {31'd0, e.valid});
            check($sformatf("step%0d_squash", n), {31'd0, bus.SQUASH_IF}, {31'd0, e.sq});
            check($sformatf("step%0d_pending", n), {31'd0, bus.PENDING}, {31'd0, e.pend});
            check($sformatf("step%0d_excnt", n), {16'd0, bus.EX_REDIR_COUNT}, {16'd0, e.exc});
            check($sformatf("step%0d_idcnt", n), {16'd0, bus.ID_REDIR_COUNT}, {16'd0, e.idc});
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic valid, input logic sq, input logic pend);
        exp_t e;
        e.pc = pc; e.valid = valid; e.sq = sq; e.pend = pend;
`ifdef REDIRECT_STATS_EN
        e.exc = expEx; e.idc = expId;
`else
        e.exc = '0; e.idc = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic resetStep(input int n, input logic st);
        rst = 1'b1;
        bus.STALL = st;
        bus.ID_REDIRECT = 1'b0; bus.ID_TARGET = '0;
        bus.EX_MISPREDICT = 1'b0; bus.EX_TARGET = '0;
        expEx = '0; expId = '0;
        pushExp(RV, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        compareOut(n);
    endtask

    task automatic step(input int n, input logic st,
                        input logic idr, input logic [31:0] idt,
                        input logic exm, input logic [31:0] ext,
                        input logic [31:0] epc, input logic epend, input int src, input logic evalid);
        rst = 1'b0;
        bus.STALL = st;
        bus.ID_REDIRECT = idr; bus.ID_TARGET = idt;
        bus.EX_MISPREDICT = exm; bus.EX_TARGET = ext;
        if (src == SRC_EX) expEx++;
        if (src == SRC_ID) expId++;
        pushExp(epc, evalid, (src == SRC_EX), epend);
        @(posedge clk); #1;
        compareOut(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetStep(0, 1'b0);
        resetStep(1, 1'b0);
        // First valid cycle: redirects ignored, reset vector presented
        step(2, 0, 1, 32'h0000_1234, 1, 32'h0000_9000, RV, 0, SRC_SEQ, 1);
        step(3, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0, SRC_SEQ, 1);
        step(4, 0, 0, 0, 0, 0, 32'hBFC0_0008, 0, SRC_SEQ, 1);
        step(5, 0, 1, 32'h0040_0010, 0, 0, 32'h0040_0010, 0, SRC_ID, 1);
        step(6, 0, 1, 32'h0040_0100, 0, 0, 32'h0040_0100, 0, SRC_ID, 1);
        step(7, 0, 1, 32'h0040_0300, 1, 32'h0040_0200, 32'h0040_0200, 0, SRC_EX, 1);
        step(8, 0, 0, 0, 0, 0, 32'h0040_0204, 0, SRC_SEQ, 1);
        // Four-cycle stall: ID, EX overwrites, later ID ignored, released to EX
        step(9,  1, 1, 32'h0000_1000, 0, 0, 32'h0040_0204, 1, SRC_SEQ, 1);
        step(10, 1, 0, 0, 1, 32'h0000_2000, 32'h0040_0204, 1, SRC_SEQ, 1);
        step(11, 1, 1, 32'h0000_3000, 0, 0, 32'h0040_0204, 1, SRC_SEQ, 1);
        step(12, 1, 0, 0, 0, 0, 32'h0040_0204, 1, SRC_SEQ, 1);
        step(13, 0, 0, 0, 0, 0, 32'h0000_2000, 0, SRC_EX, 1);
        step(14, 0, 0, 0, 0, 0, 32'h0000_2004, 0, SRC_SEQ, 1);
        // Live EX at release beats a pending ID, which is discarded
        step(15, 1, 1, 32'h0000_1000, 0, 0, 32'h0000_2004, 1, SRC_SEQ, 1);
        step(16, 0, 0, 0, 1, 32'h0000_5000, 32'h0000_5000, 0, SRC_EX, 1);
        step(17, 0, 0, 0, 0, 0, 32'h0000_5004, 0, SRC_SEQ, 1);
        // Live ID beats pending ID; pending ID applied when nothing live
        step(18, 1, 1, 32'h0000_6000, 0, 0, 32'h0000_5004, 1, SRC_SEQ, 1);
        step(19, 1, 0, 0, 0, 0, 32'h0000_5004, 1, SRC_SEQ, 1);
        step(20, 0, 1, 32'h0000_7000, 0, 0, 32'h0000_7000, 0, SRC_ID, 1);
        step(21, 1, 1, 32'h0000_8000, 0, 0, 32'h0000_7000, 1, SRC_SEQ, 1);
        step(22, 0, 0, 0, 0, 0, 32'h0000_8000, 0, SRC_ID, 1);
        // HOLD then EX latched; ID ignored; pending EX beats live ID
        step(23, 1, 0, 0, 0, 0, 32'h0000_8000, 0, SRC_SEQ, 1);
        step(24, 1, 0, 0, 1, 32'h0000_9000, 32'h0000_8000, 1, SRC_SEQ, 1);
        step(25, 1, 1, 32'h0000_A000, 0, 0, 32'h0000_8000, 1, SRC_SEQ, 1);
        step(26, 0, 1, 32'h0000_B000, 0, 0, 32'h0000_9000, 0, SRC_EX, 1);
        // Release from plain HOLD behaves as RUN
        step(27, 1, 0, 0, 0, 0, 32'h0000_9000, 0, SRC_SEQ, 1);
        step(28, 0, 1, 32'h0000_C000, 0, 0, 32'h0000_C000, 0, SRC_ID, 1);
        // Wraparound and target alignment
        step(29, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, SRC_EX, 1);
        step(30, 0, 0, 0, 0, 0, 32'h0000_0000, 0, SRC_SEQ, 1);
        step(31, 0, 0, 0, 1, 32'h0040_0203, 32'h0040_0200, 0, SRC_EX, 1);
        step(32, 0, 1, 32'h0040_0303, 0, 0, 32'h0040_0300, 0, SRC_ID, 1);
        // Reset in HOLD_PEND discards the pending redirect
        step(33, 1, 1, 32'h0000_1000, 0, 0, 32'h0040_0300, 1, SRC_SEQ, 1);
        resetStep(34, 1'b1);
        step(35, 0, 0, 0, 0, 0, RV, 0, SRC_SEQ, 1);
        step(36, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0, SRC_SEQ, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
